// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: 800x525 counters, game-pixel coordinates, and
// sync/blank realignment with the sprite colour returned after PIPE_DELAY cycles.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter int unsigned PIPE_DELAY = 1
) (
  input  logic       VGA_CLK,
  input  logic       resetn,
  input  logic [2:0] color,
  output logic [7:0] xvga,
  output logic [6:0] yvga,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       frame_tick
);

  localparam int unsigned CW       = 10;
  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam logic [7:0]  X_HOLD   = 8'(H_VISIBLE / 4 - 1);
  localparam logic [6:0]  Y_HOLD   = 7'(V_VISIBLE / 4 - 1);

  logic [CW-1:0] hcount, vcount;
  logic [CW-1:0] h_nxt, v_nxt;
  logic          run;
  logic          hs_raw, vs_raw, bl_raw;
  logic [PIPE_DELAY-1:0] hs_d, vs_d, bl_d;

  // Counter advance; held for the first edge after reset release.
  always_comb begin
    h_nxt = hcount;
    v_nxt = vcount;
    if (run) begin
      if (hcount == CW'(H_TOTAL - 1)) begin
        h_nxt = '0;
        v_nxt = (vcount == CW'(V_TOTAL - 1)) ? '0 : vcount + CW'(1);
      end else begin
        h_nxt = hcount + CW'(1);
      end
    end
  end

  always_comb begin
    hs_raw = !((hcount >= CW'(HS_START)) && (hcount < CW'(HS_END)));
    vs_raw = !((vcount >= CW'(VS_START)) && (vcount < CW'(VS_END)));
    bl_raw = (hcount < CW'(H_VISIBLE)) && (vcount < CW'(V_VISIBLE));
  end

  // Counters and the coordinate/tick outputs that track them.
  always_ff @(posedge VGA_CLK or negedge resetn) begin
    if (!resetn) begin
      run        <= 1'b0;
      hcount     <= '0;
      vcount     <= '0;
      xvga       <= '0;
      yvga       <= '0;
      frame_tick <= 1'b0;
    end else begin
      run        <= 1'b1;
      hcount     <= h_nxt;
      vcount     <= v_nxt;
      xvga       <= (h_nxt < CW'(H_VISIBLE)) ? h_nxt[9:2] : X_HOLD;
      yvga       <= (v_nxt < CW'(V_VISIBLE)) ? v_nxt[8:2] : Y_HOLD;
      frame_tick <= run && (h_nxt == '0) && (v_nxt == CW'(V_VISIBLE));
    end
  end

  // Sync/blank delay line matching the sprite_manager colour latency.
  always_ff @(posedge VGA_CLK or negedge resetn) begin
    if (!resetn) begin
      hs_d <= '1;
      vs_d <= '1;
      bl_d <= '0;
    end else begin
      hs_d <= PIPE_DELAY'({hs_d, hs_raw});
      vs_d <= PIPE_DELAY'({vs_d, vs_raw});
      bl_d <= PIPE_DELAY'({bl_d, bl_raw});
    end
  end

  always_ff @(posedge VGA_CLK or negedge resetn) begin
    if (!resetn) begin
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else begin
      VGA_HS      <= hs_d[PIPE_DELAY-1];
      VGA_VS      <= vs_d[PIPE_DELAY-1];
      VGA_BLANK_N <= bl_d[PIPE_DELAY-1];
      VGA_R       <= bl_d[PIPE_DELAY-1] ? {8{color[2]}} : 8'h00;
      VGA_G       <= bl_d[PIPE_DELAY-1] ? {8{color[1]}} : 8'h00;
      VGA_B       <= bl_d[PIPE_DELAY-1] ? {8{color[0]}} : 8'h00;
    end
  end

endmodule
